// File: rtl/ebi_chan_regs_if.sv
// EBI-side register access bundle: word address, level we/re, byte enables,
// write data out to the bank, registered read data back to the EBI interface.
interface ebi_chan_regs_if #(
  parameter int ADDR_W = 22
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic              re;
  logic [3:0]        be;
  logic [31:0]       write_data;
  logic [31:0]       read_data;

  modport master (
    output addr, we, re, be, write_data,
    input  read_data
  );

  modport slave (
    input  addr, we, re, be, write_data,
    output read_data
  );
endinterface

// File: rtl/ebi_chan_regs.sv
// Register bank between EBI and NCH serial channels plus global irq block.
// Ports: clk/rst_n, bus (EBI slave), per-channel cr/tdr/sr/rdr, strobes, irq.
module ebi_chan_regs #(
  parameter int NCH       = 6,
  parameter int ADDR_W    = 22,
  parameter int GLOB_BASE = 'h100
) (
  input  logic              clk,
  input  logic              rst_n,
  ebi_chan_regs_if.slave    bus,
  output logic [NCH*32-1:0] cr_o,
  output logic [NCH*32-1:0] tdr_o,
  input  logic [NCH*32-1:0] sr_i,
  input  logic [NCH*32-1:0] rdr_i,
  output logic [NCH-1:0]    tx_write_o,
  output logic [NCH-1:0]    rx_read_o,
  output logic [NCH-1:0]    sr_read_o,
  input  logic [NCH-1:0]    chan_irq_i,
  output logic              irq_o
);

  localparam logic [31:0] NMASK =
    32'((64'd1 << NCH) - 64'd1);
  localparam logic [1:0] OFF_CR  = 2'd0;
  localparam logic [1:0] OFF_SR  = 2'd1;
  localparam logic [1:0] OFF_TDR = 2'd2;
  localparam logic [1:0] OFF_RDR = 2'd3;

  logic              armed;
  logic              we_q;
  logic              re_q;
  logic [NCH-1:0]    irq_q;
  logic [31:0]       ipr;
  logic [31:0]       imr;

  logic [ADDR_W-1:0] a;
  logic [1:0]        off;
  logic              is_chan;
  logic              is_ipr;
  logic              is_imr;
  logic              is_ivr;
  logic [NCH-1:0]    chsel;
  logic              wr_acc;
  logic              rd_acc;
  logic [31:0]       bmask;
  logic [31:0]       pend;
  logic [31:0]       ivr;
  logic [31:0]       rd_val;
  logic [31:0]       ipr_set;
  logic [31:0]       ipr_clr;

  assign a       = bus.addr;
  assign off     = a[1:0];
  assign is_chan = a < ADDR_W'(NCH * 4);
  assign is_ipr  = a == ADDR_W'(GLOB_BASE);
  assign is_imr  = a == ADDR_W'(GLOB_BASE + 1);
  assign is_ivr  = a == ADDR_W'(GLOB_BASE + 2);

  always_comb begin
    chsel = '0;
    for (int c = 0; c < NCH; c++)
      chsel[c] = is_chan &&
        (a[ADDR_W-1:2] == (ADDR_W-2)'(c));
  end

  // armed blocks the first cycle after reset so a level held
  // through reset is not mistaken for a fresh edge.
  assign wr_acc = armed & bus.we & ~we_q;
  assign rd_acc = armed & bus.re & ~re_q & ~wr_acc;

  assign bmask = {{8{bus.be[3]}}, {8{bus.be[2]}},
                  {8{bus.be[1]}}, {8{bus.be[0]}}};

  assign pend    = ipr & imr;
  assign ipr_set = 32'(chan_irq_i & ~irq_q);
  assign ipr_clr = (wr_acc && is_ipr) ?
                   (bus.write_data & bmask) : '0;

  // Lowest pending index wins: scan high to low, last hit stays.
  always_comb begin
    ivr = '0;
    for (int c = NCH - 1; c >= 0; c--)
      if (pend[c]) ivr[4:0] = 5'(c);
    ivr[31] = |pend;
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      is_chan: begin
        for (int c = 0; c < NCH; c++) begin
          if (chsel[c]) begin
            unique case (off)
              OFF_CR:  rd_val = cr_o[32*c +: 32];
              OFF_SR:  rd_val = sr_i[32*c +: 32];
              OFF_RDR: rd_val = rdr_i[32*c +: 32];
              default: rd_val = '0;
            endcase
          end
        end
      end
      is_ipr:  rd_val = ipr;
      is_imr:  rd_val = imr;
      is_ivr:  rd_val = ivr;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed         <= 1'b0;
      we_q          <= 1'b0;
      re_q          <= 1'b0;
      irq_q         <= '0;
      cr_o          <= '0;
      tdr_o         <= '0;
      tx_write_o    <= '0;
      rx_read_o     <= '0;
      sr_read_o     <= '0;
      bus.read_data <= '0;
      ipr           <= '0;
      imr           <= '0;
      irq_o         <= 1'b0;
    end else begin
      armed      <= 1'b1;
      we_q       <= bus.we;
      re_q       <= bus.re;
      irq_q      <= chan_irq_i;
      tx_write_o <= '0;
      rx_read_o  <= '0;
      sr_read_o  <= '0;
      for (int c = 0; c < NCH; c++) begin
        if (wr_acc && chsel[c] && off == OFF_CR)
          cr_o[32*c +: 32] <=
            (cr_o[32*c +: 32] & ~bmask) |
            (bus.write_data & bmask);
        // Strobe fires even with be=0 so the channel sees the access.
        if (wr_acc && chsel[c] && off == OFF_TDR) begin
          tdr_o[32*c +: 32] <=
            (tdr_o[32*c +: 32] & ~bmask) |
            (bus.write_data & bmask);
          tx_write_o[c] <= 1'b1;
        end
        if (rd_acc && chsel[c] && off == OFF_SR)
          sr_read_o[c] <= 1'b1;
        if (rd_acc && chsel[c] && off == OFF_RDR)
          rx_read_o[c] <= 1'b1;
      end
      if (rd_acc)
        bus.read_data <= rd_val;
      // Set is or-ed in after the clear so a new edge beats a W1C.
      ipr <= ((ipr & ~ipr_clr) | ipr_set) & NMASK;
      if (wr_acc && is_imr)
        imr <= ((imr & ~bmask) |
                (bus.write_data & bmask)) & NMASK;
      irq_o <= |pend;
    end
  end

endmodule

// File: tb/tb_ebi_chan_regs.sv
// Self-checking bench for ebi_chan_regs: scoreboard queue of expected
// values, one task per feature, single summary line at the end.
module tb_ebi_chan_regs;
  localparam int NCH    = 6;
  localparam int ADDR_W = 22;
  localparam int GB     = 'h100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ebi_chan_regs_if #(.ADDR_W(ADDR_W)) bus ();

  logic [NCH*32-1:0] cr_o, tdr_o, sr_i, rdr_i;
  logic [NCH-1:0]    tx_write_o, rx_read_o, sr_read_o;
  logic [NCH-1:0]    chan_irq_i;
  logic              irq_o;

  ebi_chan_regs #(.NCH(NCH), .ADDR_W(ADDR_W), .GLOB_BASE(GB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .cr_o       (cr_o),
    .tdr_o      (tdr_o),
    .sr_i       (sr_i),
    .rdr_i      (rdr_i),
    .tx_write_o (tx_write_o),
    .rx_read_o  (rx_read_o),
    .sr_read_o  (sr_read_o),
    .chan_irq_i (chan_irq_i),
    .irq_o      (irq_o)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [ADDR_W-1:0] a,
                           input logic [31:0] d,
                           input logic [3:0] b, input int hold);
    bus.addr = a; bus.write_data = d; bus.be = b; bus.we = 1'b1;
    repeat (hold) tick();
    bus.we = 1'b0;
    tick();
  endtask

  task automatic bus_read(input logic [ADDR_W-1:0] a,
                          input int hold, output logic [31:0] obs);
    bus.addr = a; bus.re = 1'b1;
    tick();
    obs = bus.read_data;
    repeat (hold - 1) tick();
    bus.re = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] obs, e;
    logic [ADDR_W-1:0] a;
    rst_n = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (cr_o !== '0 || tdr_o !== '0 || bus.read_data !== '0 ||
        tx_write_o !== '0 || rx_read_o !== '0 ||
        sr_read_o !== '0 || irq_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: cr=%h tdr=%h rd=%h irq=%b, want all 0",
               cr_o, tdr_o, bus.read_data, irq_o);
    end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NCH * 4 + 3; i++) begin
      if (i < NCH * 4) begin
        a = ADDR_W'(i);
        case (i % 4)
          1:       e = sr_i[32*(i/4) +: 32];
          3:       e = rdr_i[32*(i/4) +: 32];
          default: e = 32'h0;
        endcase
      end else begin
        a = ADDR_W'(GB + i - NCH * 4);
        e = 32'h0;
      end
      exp_q.push_back(e);
      bus_read(a, 1, obs);
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL reset_read[%h]: got %h want %h", a, obs, e);
      end
    end
  endtask

  task automatic test_byte_en();
    logic [31:0] obs, e;
    bus_write(22'd20, 32'h0000_1234, 4'hF, 1);
    bus_write(22'd20, 32'hA5A5_0000, 4'b1100, 3);
    n_vec++;
    if (cr_o[160 +: 32] !== 32'hA5A5_1234) begin
      n_err++;
      $display("FAIL be_cr5: got %h want a5a51234", cr_o[160 +: 32]);
    end
    n_vec++;
    if (cr_o[0 +: 160] !== '0) begin
      n_err++;
      $display("FAIL be_others: got %h want 0", cr_o[0 +: 160]);
    end
    exp_q.push_back(32'hA5A5_1234);
    bus_read(22'd20, 2, obs);
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL be_readback: got %h want %h", obs, e);
    end
  endtask

  task automatic test_tdr_hold();
    int pulses = 0;
    logic [NCH-1:0] other = '0;
    logic [31:0] e, obs;
    bus.addr = 22'd10; bus.write_data = 32'h41;
    bus.be = 4'hF; bus.we = 1'b1;
    exp_q.push_back(32'h41);
    for (int i = 0; i < 10; i++) begin
      tick();
      other |= (tx_write_o & ~6'b000100) | rx_read_o | sr_read_o;
      if (tx_write_o[2]) begin
        pulses++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          n_vec++;
          if (tdr_o[64 +: 32] !== e) begin
            n_err++;
            $display("FAIL tdr_during_pulse: got %h want %h",
                     tdr_o[64 +: 32], e);
          end
        end
      end
    end
    bus.we = 1'b0;
    tick();
    n_vec++;
    if (pulses != 1 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL tdr_pulse_count: got %0d want 1", pulses);
      exp_q.delete();
    end
    n_vec++;
    if (other !== '0) begin
      n_err++;
      $display("FAIL tdr_other_strobes: got %b want 0", other);
    end
    exp_q.push_back(32'h0);
    bus_read(22'd10, 1, obs);
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL tdr_read_zero: got %h want %h", obs, e);
    end
  endtask

  task automatic test_rdr_read();
    int pulses = 0;
    logic [31:0] e;
    rdr_i[0 +: 32] = 32'hCAFE_0001;
    exp_q.push_back(32'hCAFE_0001);
    bus.addr = 22'd3; bus.re = 1'b1;
    tick();
    if (rx_read_o[0]) pulses++;
    e = exp_q.pop_front();
    n_vec++;
    if (bus.read_data !== e) begin
      n_err++;
      $display("FAIL rdr_latency1: got %h want %h", bus.read_data, e);
    end
    rdr_i[0 +: 32] = 32'hBEEF_0002;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rx_read_o[0]) pulses++;
    end
    bus.re = 1'b0;
    tick();
    n_vec++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL rdr_pulse_count: got %0d want 1", pulses);
    end
    n_vec++;
    if (bus.read_data !== 32'hCAFE_0001) begin
      n_err++;
      $display("FAIL rdr_hold: got %h want cafe0001", bus.read_data);
    end
  endtask

  task automatic test_irq();
    logic [31:0] obs, e;
    bus_write(22'(GB + 1), 32'h3F, 4'hF, 1);
    chan_irq_i[4] = 1'b1; tick(); chan_irq_i[4] = 1'b0; tick();
    chan_irq_i[1] = 1'b1; tick(); chan_irq_i[1] = 1'b0; tick();
    exp_q.push_back(32'h12);
    bus_read(22'(GB), 1, obs);
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL irq_ipr: got %h want %h", obs, e);
    end
    n_vec++;
    if (irq_o !== 1'b1) begin
      n_err++;
      $display("FAIL irq_high: got %b want 1", irq_o);
    end
    exp_q.push_back(32'h8000_0001);
    bus_read(22'(GB + 2), 1, obs);
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL irq_ivr1: got %h want %h", obs, e);
    end
    bus_write(22'(GB), 32'h02, 4'hF, 1);
    exp_q.push_back(32'h8000_0004);
    bus_read(22'(GB + 2), 1, obs);
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL irq_ivr4: got %h want %h", obs, e);
    end
    bus.addr = 22'(GB); bus.write_data = 32'h10;
    bus.be = 4'hF; bus.we = 1'b1;
    tick();
    n_vec++;
    if (irq_o !== 1'b1) begin
      n_err++;
      $display("FAIL irq_lag: got %b want 1", irq_o);
    end
    bus.we = 1'b0;
    tick();
    n_vec++;
    if (irq_o !== 1'b0) begin
      n_err++;
      $display("FAIL irq_low: got %b want 0", irq_o);
    end
    exp_q.push_back(32'h0);
    bus_read(22'(GB + 2), 1, obs);
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL irq_ivr0: got %h want %h", obs, e);
    end
  endtask

  task automatic test_set_wins();
    logic [31:0] obs, e;
    chan_irq_i[3] = 1'b1; tick(); chan_irq_i[3] = 1'b0; tick();
    bus.addr = 22'(GB); bus.write_data = 32'h08;
    bus.be = 4'hF; bus.we = 1'b1; chan_irq_i[3] = 1'b1;
    tick();
    bus.we = 1'b0; chan_irq_i[3] = 1'b0;
    tick();
    exp_q.push_back(32'h08);
    bus_read(22'(GB), 1, obs);
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL set_wins: got %h want %h", obs, e);
    end
    bus_write(22'(GB), 32'h08, 4'hF, 1);
    exp_q.push_back(32'h0);
    bus_read(22'(GB), 1, obs);
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL w1c_clear: got %h want %h", obs, e);
    end
  endtask

  task automatic test_unmapped();
    logic [NCH*32-1:0] cr_s, tdr_s;
    logic [NCH-1:0] strb = '0;
    logic [31:0] obs, e;
    bus_read(22'(GB + 1), 1, obs);
    cr_s = cr_o; tdr_s = tdr_o;
    bus.addr = 22'h0FF; bus.write_data = 32'hFFFF_FFFF;
    bus.be = 4'hF; bus.we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      strb |= tx_write_o | rx_read_o | sr_read_o;
    end
    bus.we = 1'b0;
    tick();
    n_vec++;
    if (cr_o !== cr_s || tdr_o !== tdr_s || strb !== '0) begin
      n_err++;
      $display("FAIL unmapped_write: cr=%h tdr=%h strb=%b, want unchanged",
               cr_o, tdr_o, strb);
    end
    exp_q.push_back(32'h3F);
    bus_read(22'(GB + 1), 1, obs);
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL unmapped_imr: got %h want %h", obs, e);
    end
    exp_q.push_back(32'h0);
    bus_read(22'h0FF, 1, obs);
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL unmapped_read: got %h want %h", obs, e);
    end
  endtask

  task automatic test_wr_re_same();
    logic [31:0] e;
    exp_q.push_back(sr_i[32 +: 32]);
    bus.addr = 22'd5; bus.re = 1'b1;
    tick();
    e = exp_q.pop_front();
    n_vec++;
    if (bus.read_data !== e || sr_read_o !== 6'b000010) begin
      n_err++;
      $display("FAIL sr_read: data=%h strobe=%b want %h 000010",
               bus.read_data, sr_read_o, e);
    end
    bus.re = 1'b0;
    tick();
    bus.addr = 22'd4; bus.write_data = 32'h77;
    bus.be = 4'hF; bus.we = 1'b1; bus.re = 1'b1;
    tick();
    bus.we = 1'b0; bus.re = 1'b0;
    tick();
    n_vec++;
    if (bus.read_data !== e || cr_o[32 +: 32] !== 32'h77) begin
      n_err++;
      $display("FAIL wr_re_same: rd=%h cr1=%h want %h 00000077",
               bus.read_data, cr_o[32 +: 32], e);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] obs, e;
    bus.addr = 22'd0; bus.write_data = 32'h5A;
    bus.be = 4'hF; bus.we = 1'b1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (cr_o !== '0 || irq_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: cr=%h irq=%b want 0", cr_o, irq_o);
    end
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();
    n_vec++;
    if (cr_o[0 +: 32] !== 32'h0) begin
      n_err++;
      $display("FAIL reset_no_spurious: got %h want 0", cr_o[0 +: 32]);
    end
    bus.we = 1'b0; tick();
    bus.we = 1'b1; tick();
    bus.we = 1'b0; tick();
    n_vec++;
    if (cr_o[0 +: 32] !== 32'h5A) begin
      n_err++;
      $display("FAIL reset_rearm: got %h want 0000005a", cr_o[0 +: 32]);
    end
    exp_q.push_back(32'h0);
    bus_read(22'(GB + 1), 1, obs);
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL reset_imr: got %h want %h", obs, e);
    end
  endtask

  initial begin
    bus.addr = '0; bus.we = 1'b0; bus.re = 1'b0;
    bus.be = '0; bus.write_data = '0;
    chan_irq_i = '0;
    for (int c = 0; c < NCH; c++) begin
      sr_i[32*c +: 32]  = 32'h5100_0000 + 32'(c);
      rdr_i[32*c +: 32] = 32'hD000_0000 + 32'(c * 16);
    end
    test_reset();
    test_byte_en();
    test_tdr_hold();
    test_rdr_read();
    test_irq();
    test_set_wins();
    test_unmapped();
    test_wr_re_same();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
